rptr_empty_mc: RTL and testbench

Read-side pointer/flag manager for the async FIFO family, generalised to NUM_CH independent channels sharing one read clock domain.
- Per channel: binary read address, gray read pointer for the write-side synchroniser, registered empty, occupancy level, almost-empty and sticky underflow.
- Sits between the read-domain sync_wptr synchronisers and the FIFO RAM read ports inside the crossbar's clock-crossing buffers.

---
 rtl/async_fifo_pkg.sv | 15 +
 rtl/rptr_empty_ch.sv | 59 +++++
 rtl/rptr_empty_mc.sv | 40 ++++
 tb/tb_rptr_empty_mc.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: shared pointer types and gray/binary conversion helpers for the async FIFO family
package async_fifo_pkg;
    localparam int PTR_MAX = 32;
    localparam int DEF_ADDR_SIZE = 3;
    typedef logic [DEF_ADDR_SIZE:0] ptr_t;
    function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction
    function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
        logic [PTR_MAX-1:0] b;
        b = '0;
        for (int i = 0; i < PTR_MAX; i++) b[i] = ^(g >> i);
        return b;
    endfunction
endpackage

// File: rtl/rptr_empty_ch.sv
// rptr_empty_ch: one channel's read pointer, empty/almost-empty/underflow flags and level (flush via RPTR_FLUSH_EN)
module rptr_empty_ch
    import async_fifo_pkg::*;
#(
    parameter int ADDR_SIZE = 3,
    parameter int AE_THRESH = 1
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 rpop,
`ifdef RPTR_FLUSH_EN
    input  logic                 rflush,
`endif
    input  logic [ADDR_SIZE:0]   sync_wptr,
    output logic                 rempty,
    output logic                 ralmost_empty,
    output logic                 runderflow,
    output logic [ADDR_SIZE-1:0] raddr,
    output logic [ADDR_SIZE:0]   rptr,
    output logic [ADDR_SIZE:0]   rlevel
);
    localparam int W = ADDR_SIZE + 1;
    localparam logic [W-1:0] AE = W'(AE_THRESH);
    logic [W-1:0] rbin, rbin_nxt, rgray_nxt, wbin, rlevel_nxt;
    logic         uf_nxt;
    assign wbin = W'(gray2bin(PTR_MAX'(sync_wptr)));
    // next binary pointer: flush jumps to the write pointer, otherwise advance on an accepted pop
    always_comb begin
`ifdef RPTR_FLUSH_EN
        rbin_nxt = rflush ? wbin : rbin + W'(rpop & ~rempty);
        uf_nxt   = runderflow | (rpop & rempty & ~rflush);
`else
        rbin_nxt = rbin + W'(rpop & ~rempty);
        uf_nxt   = runderflow | (rpop & rempty);
`endif
    end
    assign rgray_nxt  = W'(bin2gray(PTR_MAX'(rbin_nxt)));
    assign rlevel_nxt = wbin - rbin_nxt;
    // pointer and flag registers, all refreshed every cycle
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin          <= '0;
            raddr         <= '0;
            rptr          <= '0;
            rempty        <= 1'b1;
            rlevel        <= '0;
            ralmost_empty <= 1'b1;
            runderflow    <= 1'b0;
        end else begin
            rbin          <= rbin_nxt;
            raddr         <= rbin_nxt[ADDR_SIZE-1:0];
            rptr          <= rgray_nxt;
            rempty        <= rgray_nxt == sync_wptr;
            rlevel        <= rlevel_nxt;
            ralmost_empty <= rlevel_nxt <= AE;
            runderflow    <= uf_nxt;
        end
    end
endmodule

// File: rtl/rptr_empty_mc.sv
// rptr_empty_mc: NUM_CH independent read-side pointer/flag managers on one read clock (flush via RPTR_FLUSH_EN)
module rptr_empty_mc
    import async_fifo_pkg::*;
#(
    parameter int ADDR_SIZE = 3,
    parameter int NUM_CH    = 4,
    parameter int AE_THRESH = 1
) (
    input  logic                                rclk,
    input  logic                                rrst,
    input  logic [NUM_CH-1:0]                   rpop,
`ifdef RPTR_FLUSH_EN
    input  logic [NUM_CH-1:0]                   rflush,
`endif
    input  logic [NUM_CH-1:0][ADDR_SIZE:0]      sync_wptr,
    output logic [NUM_CH-1:0]                   rempty,
    output logic [NUM_CH-1:0]                   ralmost_empty,
    output logic [NUM_CH-1:0]                   runderflow,
    output logic [NUM_CH-1:0][ADDR_SIZE-1:0]    raddr,
    output logic [NUM_CH-1:0][ADDR_SIZE:0]      rptr,
    output logic [NUM_CH-1:0][ADDR_SIZE:0]      rlevel
);
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        rptr_empty_ch #(.ADDR_SIZE(ADDR_SIZE), .AE_THRESH(AE_THRESH)) u_ch (
            .rclk          (rclk),
            .rrst          (rrst),
            .rpop          (rpop[g]),
`ifdef RPTR_FLUSH_EN
            .rflush        (rflush[g]),
`endif
            .sync_wptr     (sync_wptr[g]),
            .rempty        (rempty[g]),
            .ralmost_empty (ralmost_empty[g]),
            .runderflow    (runderflow[g]),
            .raddr         (raddr[g]),
            .rptr          (rptr[g]),
            .rlevel        (rlevel[g])
        );
    end
endmodule

// File: tb/tb_rptr_empty_mc.sv
// tb_rptr_empty_mc: directed and random checks of rptr_empty_mc against a count-based FIFO model
module tb_rptr_empty_mc;
    localparam int AS = 3;
    localparam int NC = 4;
    logic               rclk = 1'b0;
    logic               rrst = 1'b1;
    logic [NC-1:0]      rpop = '0;
    logic [NC-1:0][AS:0] sync_wptr = '0;
    logic [NC-1:0]      rempty, ralmost_empty, runderflow;
    logic [NC-1:0][AS-1:0] raddr;
    logic [NC-1:0][AS:0] rptr, rlevel;
`ifdef RPTR_FLUSH_EN
    logic [NC-1:0]      rflush = '0;
`endif
    int total = 0;
    int bad = 0;
    int rb[NC];
    int wb[NC];
    int e_lvl[NC];
    logic e_emp[NC];
    logic e_uf[NC];

    rptr_empty_mc #(.ADDR_SIZE(AS), .NUM_CH(NC), .AE_THRESH(1)) dut (
        .rclk          (rclk),
        .rrst          (rrst),
        .rpop          (rpop),
`ifdef RPTR_FLUSH_EN
        .rflush        (rflush),
`endif
        .sync_wptr     (sync_wptr),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .runderflow    (runderflow),
        .raddr         (raddr),
        .rptr          (rptr),
        .rlevel        (rlevel)
    );

    always #5 rclk = ~rclk;

    function automatic logic [3:0] gray4(input int b);
        logic [3:0] m;
        m = 4'(b % 16);
        return m ^ (m >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NC; i++) begin
            chk($sformatf("rempty[%0d]", i), 32'(rempty[i]), 32'(e_emp[i]));
            chk($sformatf("ralmost_empty[%0d]", i), 32'(ralmost_empty[i]), 32'(e_lvl[i] <= 1));
            chk($sformatf("runderflow[%0d]", i), 32'(runderflow[i]), 32'(e_uf[i]));
            chk($sformatf("raddr[%0d]", i), 32'(raddr[i]), 32'(rb[i] % 8));
            chk($sformatf("rptr[%0d]", i), 32'(rptr[i]), 32'(gray4(rb[i])));
            chk($sformatf("rlevel[%0d]", i), 32'(rlevel[i]), 32'(e_lvl[i]));
        end
    endtask

    task automatic cyc(input logic [NC-1:0] pop, input logic rst_i, input logic [NC-1:0] fl);
        rpop = pop;
        rrst = rst_i;
`ifdef RPTR_FLUSH_EN
        rflush = fl;
`endif
        for (int i = 0; i < NC; i++) sync_wptr[i] = gray4(wb[i]);
        @(posedge rclk);
        for (int i = 0; i < NC; i++) begin
            if (rst_i) begin
                rb[i] = 0;
                e_uf[i] = 1'b0;
                e_lvl[i] = 0;
                e_emp[i] = 1'b1;
            end else begin
                if (fl[i]) rb[i] = wb[i];
                else if (pop[i] && e_emp[i]) e_uf[i] = 1'b1;
                else if (pop[i]) rb[i]++;
                e_lvl[i] = (wb[i] - rb[i]) % 16;
                e_emp[i] = e_lvl[i] == 0;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        logic [NC-1:0] p;
        logic [NC-1:0] f;
        for (int i = 0; i < NC; i++) begin
            rb[i] = 0;
            wb[i] = 0;
            e_lvl[i] = 0;
            e_emp[i] = 1'b1;
            e_uf[i] = 1'b0;
        end
        cyc('0, 1'b1, '0);
        cyc('0, 1'b1, '0);
        cyc('0, 1'b0, '0);
        wb[0] = 3;
        cyc('0, 1'b0, '0);
        chk("t2 rlevel0", 32'(rlevel[0]), 32'd3);
        cyc(4'b0001, 1'b0, '0);
        cyc(4'b0001, 1'b0, '0);
        chk("t2 ae at level1", 32'(ralmost_empty[0]), 32'd1);
        cyc(4'b0001, 1'b0, '0);
        chk("t2 rptr after 3 pops", 32'(rptr[0]), 32'b0010);
        chk("t2 empty after 3 pops", 32'(rempty[0]), 32'd1);
        wb[1] = 8;
        cyc('0, 1'b0, '0);
        for (int n = 0; n < 16; n++) begin
            wb[1] = rb[1] + 8;
            cyc(4'b0010, 1'b0, '0);
            chk("t3 no spurious empty", 32'(rempty[1]), 32'd0);
        end
        chk("t3 rb wrapped", 32'(rptr[1]), 32'(gray4(16)));
        cyc(4'b0100, 1'b0, '0);
        chk("t4 underflow set", 32'(runderflow[2]), 32'd1);
        cyc('0, 1'b0, '0);
        cyc('0, 1'b0, '0);
        wb[0] = rb[0] + 5;
        wb[3] = 2;
        cyc('0, 1'b0, '0);
        cyc(4'b1001, 1'b0, '0);
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NC; i++) begin
                if ($urandom_range(0, 3) == 0) wb[i] += $urandom_range(0, 8 - (wb[i] - rb[i]));
                p[i] = 1'($urandom_range(0, 1));
`ifdef RPTR_FLUSH_EN
                f[i] = $urandom_range(0, 19) == 0;
`else
                f[i] = 1'b0;
`endif
            end
            cyc(p, 1'b0, f);
        end
        for (int i = 0; i < NC; i++) wb[i] = 0;
        cyc(4'b1111, 1'b1, '0);
        chk("mid reset clears underflow2", 32'(runderflow[2]), 32'd0);
`ifdef RPTR_FLUSH_EN
        cyc('0, 1'b0, '0);
        wb[0] = 5;
        cyc('0, 1'b0, '0);
        chk("t6 level before flush", 32'(rlevel[0]), 32'd5);
        cyc(4'b0001, 1'b0, 4'b0001);
        chk("t6 rptr==sync_wptr", 32'(rptr[0]), 32'(gray4(5)));
        chk("t6 flush empty", 32'(rempty[0]), 32'd1);
        chk("t6 flush no underflow", 32'(runderflow[0]), 32'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
